// File: rtl/fp_unpack.sv
// Operand front end of the binary32 multiplier: two-stage valid/ready pipeline.
// Stage 1 registers the raw operand words; stage 2 holds their unpacked fields and class flags.
module fp_unpack #(
  parameter bit FTZ   = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_sign,
  output logic [7:0]       a_exp,
  output logic [23:0]      a_mant,
  output logic [3:0]       a_flags,
  output logic             b_sign,
  output logic [7:0]       b_exp,
  output logic [23:0]      b_mant,
  output logic [3:0]       b_flags,
  output logic [CNT_W-1:0] nan_count
);
  localparam int STAGES  = 2;
  localparam int NUM_OPS = 2;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [3:0]  flags;  // {nan, inf, zero, denorm}
  } unp_t;

  logic [STAGES:1]               vld_pipe;
  logic                          en1, en2, xfer_out, has_nan;
  logic [NUM_OPS-1:0][31:0]      in_word, s1_word;
  unp_t [NUM_OPS-1:0]            out_q;
  logic [CNT_W-1:0]              nan_cnt;

  function automatic unp_t classify(input logic [31:0] w);
    unp_t        r;
    logic [7:0]  e;
    logic [22:0] f;
    e       = w[30:23];
    f       = w[22:0];
    r.sign  = w[31];
    r.exp   = e;
    r.mant  = {1'b1, f};
    r.flags = 4'b0000;
    if (e == 8'hFF) begin
      if (f != '0) r.flags = 4'b1000;
      else begin
        r.flags = 4'b0100;
        r.mant  = '0;
      end
    end else if (e == 8'h00) begin
      r.mant = '0;
      if (f == '0)  r.flags = 4'b0010;
      else if (FTZ) r.flags = 4'b0011;
      else begin
        // Denormals keep their fraction with the exponent the hidden-bit math expects.
        r.flags = 4'b0001;
        r.exp   = 8'h01;
        r.mant  = {1'b0, f};
      end
    end
    return r;
  endfunction

  assign in_word  = {in_b, in_a};
  assign en2      = !vld_pipe[2] | out_ready;
  assign en1      = !vld_pipe[1] | en2;
  assign in_ready = en1;
  assign xfer_out = vld_pipe[2] & out_ready;
  assign has_nan  = out_q[0].flags[3] | out_q[1].flags[3];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      s1_word  <= '0;
      out_q    <= '0;
      nan_cnt  <= '0;
    end else begin
      if (en1) vld_pipe[1] <= in_valid;
      if (en2) vld_pipe[2] <= vld_pipe[1];
      for (int i = 0; i < NUM_OPS; i++) begin
        if (en1 && in_valid)     s1_word[i] <= in_word[i];
        if (en2 && vld_pipe[1])  out_q[i]   <= classify(s1_word[i]);
      end
      if (xfer_out && has_nan && nan_cnt != '1)
        nan_cnt <= nan_cnt + CNT_W'(1);
    end
  end

  assign out_valid = vld_pipe[2];
  assign a_sign    = out_q[0].sign;
  assign a_exp     = out_q[0].exp;
  assign a_mant    = out_q[0].mant;
  assign a_flags   = out_q[0].flags;
  assign b_sign    = out_q[1].sign;
  assign b_exp     = out_q[1].exp;
  assign b_mant    = out_q[1].mant;
  assign b_flags   = out_q[1].flags;
  assign nan_count = nan_cnt;
endmodule

// File: tb/tb_fp_unpack.sv
// Bench for fp_unpack: an FTZ=1/CNT_W=2 instance and an FTZ=0/CNT_W=8 instance share one stimulus stream.
module tb_fp_unpack;
  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] mant;
    logic [3:0]  flags;
  } unp_t;

  typedef struct {
    logic [31:0] w;
    unp_t        e1;  // expected with FTZ=1
    unp_t        e0;  // expected with FTZ=0
  } vec_t;

  logic clk = 1'b0;
  logic rst, in_valid, out_ready;
  logic [31:0] in_a, in_b;

  logic in_ready0, out_valid0, a_sign0, b_sign0;
  logic [7:0] a_exp0, b_exp0;
  logic [23:0] a_mant0, b_mant0;
  logic [3:0] a_flags0, b_flags0;
  logic [1:0] nan_count0;

  logic in_ready1, out_valid1, a_sign1, b_sign1;
  logic [7:0] a_exp1, b_exp1;
  logic [23:0] a_mant1, b_mant1;
  logic [3:0] a_flags1, b_flags1;
  logic [7:0] nan_count1;

  unp_t g0a, g0b, g1a, g1b;
  assign g0a = {a_sign0, a_exp0, a_mant0, a_flags0};
  assign g0b = {b_sign0, b_exp0, b_mant0, b_flags0};
  assign g1a = {a_sign1, a_exp1, a_mant1, a_flags1};
  assign g1b = {b_sign1, b_exp1, b_mant1, b_flags1};

  always #5 clk = ~clk;

  fp_unpack #(.FTZ(1'b1), .CNT_W(2)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid0), .out_ready(out_ready),
    .a_sign(a_sign0), .a_exp(a_exp0), .a_mant(a_mant0), .a_flags(a_flags0),
    .b_sign(b_sign0), .b_exp(b_exp0), .b_mant(b_mant0), .b_flags(b_flags0),
    .nan_count(nan_count0));

  fp_unpack #(.FTZ(1'b0), .CNT_W(8)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid1), .out_ready(out_ready),
    .a_sign(a_sign1), .a_exp(a_exp1), .a_mant(a_mant1), .a_flags(a_flags1),
    .b_sign(b_sign1), .b_exp(b_exp1), .b_mant(b_mant1), .b_flags(b_flags1),
    .nan_count(nan_count1));

  int nchk = 0, nerr = 0;
  int mcnt0, mcnt1;
  logic [63:0] q[$];
  bit hold, acc;
  logic [127:0] held0, held1;
  vec_t tbl[10];

  function automatic unp_t pk(input logic s, input logic [7:0] e, input logic [23:0] m,
                              input logic [3:0] f);
    unp_t r;
    r.sign = s; r.exp = e; r.mant = m; r.flags = f;
    return r;
  endfunction

  // Classes by magnitude ordering of the 31-bit encoding.
  function automatic unp_t ref_cls(input logic [31:0] w, input bit ftz);
    logic [30:0] m;
    m = w[30:0];
    if (m > 31'h7F800000)       return pk(w[31], 8'hFF, {1'b1, w[22:0]}, 4'b1000);
    else if (m == 31'h7F800000) return pk(w[31], 8'hFF, 24'h0, 4'b0100);
    else if (m == 31'h0)        return pk(w[31], 8'h00, 24'h0, 4'b0010);
    else if (m < 31'h00800000)
      return ftz ? pk(w[31], 8'h00, 24'h0, 4'b0011)
                 : pk(w[31], 8'h01, {1'b0, w[22:0]}, 4'b0001);
    else                        return pk(w[31], w[30:23], {1'b1, w[22:0]}, 4'b0000);
  endfunction

  function automatic logic [31:0] rw();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: r[30:23] = 8'hFF;
      1: begin r[30:23] = 8'hFF; r[22:0] = '0; end
      2: r[30:23] = 8'h00;
      3: r[30:0] = '0;
      default: ;
    endcase
    return r;
  endfunction

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic mon();
    int n;
    bit exp_rdy;
    logic [63:0] w;
    unp_t ea, eb;
    n = q.size();
    exp_rdy = !(n == 2 && !out_ready);
    chk("in_ready0", in_ready0, exp_rdy);
    chk("in_ready1", in_ready1, exp_rdy);
    chk("nan_count0", nan_count0, mcnt0);
    chk("nan_count1", nan_count1, mcnt1);
    if (n == 0) begin
      chk("idle_valid0", out_valid0, 0);
      chk("idle_valid1", out_valid1, 0);
    end
    if (hold) begin
      chk("hold_valid", {out_valid0, out_valid1}, 2'b11);
      chk("hold_data0", {g0a, g0b}, held0);
      chk("hold_data1", {g1a, g1b}, held1);
    end
    hold  = out_valid0 && !out_ready;
    held0 = {g0a, g0b};
    held1 = {g1a, g1b};
    acc   = 1'b0;
    if (out_valid0 && out_ready) begin
      if (n == 0) chk("unexpected_out", 1, 0);
      else begin
        w  = q.pop_front();
        ea = ref_cls(w[31:0], 1'b1);
        eb = ref_cls(w[63:32], 1'b1);
        chk("out0", {g0a, g0b}, {ea, eb});
        chk("out1", {g1a, g1b}, {ref_cls(w[31:0], 1'b0), ref_cls(w[63:32], 1'b0)});
        if (ea.flags[3] | eb.flags[3]) begin
          if (mcnt0 < 3)   mcnt0++;
          if (mcnt1 < 255) mcnt1++;
        end
      end
    end
    if (in_valid && in_ready0) begin
      q.push_back({in_b, in_a});
      acc = 1'b1;
    end
  endtask

  task automatic cycle();
    #1 mon();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    mcnt0 = 0; mcnt1 = 0; hold = 1'b0;
    #1;
    chk("rst_valid", {out_valid0, out_valid1}, 2'b00);
    chk("rst_ready", {in_ready0, in_ready1}, 2'b11);
    chk("rst_count", {nan_count0, nan_count1}, 0);
    chk("rst_data", {g0a, g0b, g1a, g1b}, 0);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10 && q.size() > 0; k++) cycle();
    chk("drain_left", q.size(), 0);
  endtask

  task automatic setv(input int i, input logic [31:0] w, input logic [36:0] e1,
                      input logic [36:0] e0);
    tbl[i].w = w; tbl[i].e1 = e1; tbl[i].e0 = e0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int c, k, j;
    setv(0, 32'h3F800000, pk(0, 8'h7F, 24'h800000, 4'h0), pk(0, 8'h7F, 24'h800000, 4'h0));
    setv(1, 32'h40000000, pk(0, 8'h80, 24'h800000, 4'h0), pk(0, 8'h80, 24'h800000, 4'h0));
    setv(2, 32'h7F800000, pk(0, 8'hFF, 24'h000000, 4'h4), pk(0, 8'hFF, 24'h000000, 4'h4));
    setv(3, 32'hFFC00000, pk(1, 8'hFF, 24'hC00000, 4'h8), pk(1, 8'hFF, 24'hC00000, 4'h8));
    setv(4, 32'h00000001, pk(0, 8'h00, 24'h000000, 4'h3), pk(0, 8'h01, 24'h000001, 4'h1));
    setv(5, 32'h80000000, pk(1, 8'h00, 24'h000000, 4'h2), pk(1, 8'h00, 24'h000000, 4'h2));
    setv(6, 32'h7F800001, pk(0, 8'hFF, 24'h800001, 4'h8), pk(0, 8'hFF, 24'h800001, 4'h8));
    setv(7, 32'h807FFFFF, pk(1, 8'h00, 24'h000000, 4'h3), pk(1, 8'h01, 24'h7FFFFF, 4'h1));
    setv(8, 32'h00800000, pk(0, 8'h01, 24'h800000, 4'h0), pk(0, 8'h01, 24'h800000, 4'h0));
    setv(9, 32'h7F7FFFFF, pk(0, 8'hFE, 24'hFFFFFF, 4'h0), pk(0, 8'hFE, 24'hFFFFFF, 4'h0));

    in_a = '0; in_b = '0; out_ready = 1'b0;
    do_reset();

    // Directed vectors: exact 2-cycle latency and field values.
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      j = (i + 1) % 10;
      in_a = tbl[i].w; in_b = tbl[j].w; in_valid = 1'b1;
      cycle();
      chk("vec_accept", acc, 1);
      in_valid = 1'b0;
      #1 chk("vec_lat1", out_valid0, 0);
      cycle();
      #1;
      chk("vec_valid", out_valid0, 1);
      chk("vec_a_ftz1", g0a, tbl[i].e1);
      chk("vec_b_ftz1", g0b, tbl[j].e1);
      chk("vec_a_ftz0", g1a, tbl[i].e0);
      chk("vec_b_ftz0", g1b, tbl[j].e0);
    end
    drain();

    // Back-to-back pairs with a 3-cycle downstream stall.
    out_ready = 1'b0;
    c = 0;
    for (int i = 0; i < 4; i++) begin
      in_a = 32'h40000000 + (i << 20); in_b = 32'hC0000000 + i; in_valid = 1'b1;
      if (i == 2) #1 chk("stall_ready", in_ready0, 0);
      k = 0;
      do begin
        if (c >= 3) out_ready = 1'b1;
        cycle();
        c++; k++;
      end while (!acc && k < 10);
      chk("stall_accept", acc, 1);
    end
    drain();

    // Saturation of the 2-bit counter.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_a = 32'h7FC00000 | i; in_b = 32'h3F800000; in_valid = 1'b1;
      cycle();
    end
    drain();
    #1;
    chk("sat_count0", nan_count0, 3);
    chk("sat_count1", nan_count1, 5);

    // Reset with two pairs in flight drops them.
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_a = 32'h7FC00001; in_b = 32'h12345678 + i; in_valid = 1'b1;
      cycle();
    end
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) cycle();
    #1 chk("post_rst_count", nan_count0, 0);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 800; i++) begin
      in_valid  = ($urandom % 4) != 0;
      out_ready = ($urandom % 3) != 0;
      in_a = rw(); in_b = rw();
      cycle();
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
